// File: rtl/hcsr04_emulator_if.sv
// Trigger/echo pin pair plus distance configuration and status for the HC-SR04 responder model.
interface hcsr04_emulator_if;
    logic        trigger;
    logic [15:0] dist_ticks;
    logic        object_present;
    logic        echo;
    logic        busy;
    logic        trig_err;
    logic [15:0] meas_count;

    modport master (
        output trigger, dist_ticks, object_present,
        input  echo, busy, trig_err, meas_count
    );

    modport slave (
        input  trigger, dist_ticks, object_present,
        output echo, busy, trig_err, meas_count
    );
endinterface

// File: rtl/hcsr04_emulator.sv
// HC-SR04 responder model: qualifies a trigger pulse, waits out the burst, then returns an
// echo whose width is the programmed distance in ticks of TICK_DIV clocks.
//
// state   | meaning
// IDLE    | waiting for a rising edge on the synced trigger
// TRIG    | trigger high, measuring its width
// BURST   | valid trigger seen, modelling the ultrasonic burst delay
// ECHO    | echo output high for len ticks
// HOLDOFF | dead time after echo, triggers ignored
module hcsr04_emulator #(
    parameter int TICK_DIV        = 500,
    parameter int MIN_TRIG_CYCLES = 500,
    parameter int BURST_TICKS     = 25,
    parameter int MAX_TICKS       = 3800,
    parameter int HOLDOFF_TICKS   = 6000
) (
    input  logic               clk,
    input  logic               rst,
    hcsr04_emulator_if.slave   bus
);

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]     MIN_W      = 16'(MIN_TRIG_CYCLES);
    localparam logic [15:0]     MAX_T      = 16'(MAX_TICKS);
    localparam logic [15:0]     BURST_LAST = 16'(BURST_TICKS - 1);
    localparam logic [15:0]     HOLD_LAST  = 16'(HOLDOFF_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG    = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          trig_m_q, trig_m_d;
    logic          trig_s_q, trig_s_d;
    logic          trig_p_q, trig_p_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   width_q, width_d;
    logic [15:0]   tick_cnt_q, tick_cnt_d;
    logic [15:0]   len_q, len_d;
    logic          echo_q, echo_d;
    logic          trig_err_q, trig_err_d;
    logic [15:0]   meas_count_q, meas_count_d;

    logic          tick;
    logic          trig_rise;
    logic [15:0]   clamp_len;

    always_comb begin
        state_d      = state_q;
        trig_m_d     = bus.trigger;
        trig_s_d     = trig_m_q;
        trig_p_d     = trig_s_q;
        width_d      = width_q;
        tick_cnt_d   = tick_cnt_q;
        len_d        = len_q;
        trig_err_d   = 1'b0;
        meas_count_d = meas_count_q;

        tick      = (presc_q == PRESC_LAST);
        presc_d   = tick ? '0 : presc_q + PW'(1);
        trig_rise = trig_s_q & ~trig_p_q;

        // Zero distance still yields a one-tick echo; oversize distances clamp.
        if (!bus.object_present || bus.dist_ticks > MAX_T)
            clamp_len = MAX_T;
        else if (bus.dist_ticks == 16'd0)
            clamp_len = 16'd1;
        else
            clamp_len = bus.dist_ticks;

        case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    state_d = TRIG;
                    width_d = 16'd1;
                end
            end
            TRIG: begin
                if (trig_s_q) begin
                    if (width_q < MIN_W)
                        width_d = width_q + 16'd1;
                end else if (width_q >= MIN_W) begin
                    state_d    = BURST;
                    len_d      = clamp_len;
                    tick_cnt_d = BURST_LAST;
                end else begin
                    state_d    = IDLE;
                    trig_err_d = 1'b1;
                end
            end
            BURST: begin
                if (tick) begin
                    if (tick_cnt_q == 16'd0) begin
                        state_d    = ECHO;
                        tick_cnt_d = len_q - 16'd1;
                    end else begin
                        tick_cnt_d = tick_cnt_q - 16'd1;
                    end
                end
            end
            ECHO: begin
                if (tick) begin
                    if (tick_cnt_q == 16'd0) begin
                        state_d      = HOLDOFF;
                        tick_cnt_d   = HOLD_LAST;
                        meas_count_d = meas_count_q + 16'd1;
                    end else begin
                        tick_cnt_d = tick_cnt_q - 16'd1;
                    end
                end
            end
            HOLDOFF: begin
                if (tick) begin
                    if (tick_cnt_q == 16'd0)
                        state_d = IDLE;
                    else
                        tick_cnt_d = tick_cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Restart the prescaler on entry to each timed phase so phases are whole ticks.
        if (state_d != state_q &&
            (state_d == BURST || state_d == ECHO || state_d == HOLDOFF))
            presc_d = '0;

        echo_d = (state_d == ECHO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            trig_m_q     <= 1'b0;
            trig_s_q     <= 1'b0;
            trig_p_q     <= 1'b0;
            presc_q      <= '0;
            width_q      <= 16'd0;
            tick_cnt_q   <= 16'd0;
            len_q        <= 16'd0;
            echo_q       <= 1'b0;
            trig_err_q   <= 1'b0;
            meas_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            trig_m_q     <= trig_m_d;
            trig_s_q     <= trig_s_d;
            trig_p_q     <= trig_p_d;
            presc_q      <= presc_d;
            width_q      <= width_d;
            tick_cnt_q   <= tick_cnt_d;
            len_q        <= len_d;
            echo_q       <= echo_d;
            trig_err_q   <= trig_err_d;
            meas_count_q <= meas_count_d;
        end
    end

    assign bus.echo       = echo_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.trig_err   = trig_err_q;
    assign bus.meas_count = meas_count_q;

endmodule
